// File: rtl/mac4b_exec_queue_if.sv
// CV-X-IF issue/commit/result bundle between the core side and the MAC execution queue.
// Latency: none, this file holds wires only.
// Backpressure: issue uses issue_ready_o, result uses result_ready_i; commit is a strobe and cannot be stalled.
// Ports: issue (valid/ready/accept, id, rd, rs1..rs3), commit (valid, id, kill),
//        result (valid/ready, id, rd, data, we).
// Modports: master = core/decoder side, slave = execution queue.
interface mac4b_exec_queue_if #(
  parameter int IdWidth = 3,
  parameter int XLen    = 32
);
  // Issue
  logic               issue_valid_i;
  logic               issue_ready_o;
  logic               accept_i;
  logic [IdWidth-1:0] issue_id_i;
  logic [4:0]         rd_i;
  logic [XLen-1:0]    rs1_i;
  logic [XLen-1:0]    rs2_i;
  logic [XLen-1:0]    rs3_i;
  // Commit
  logic               commit_valid_i;
  logic [IdWidth-1:0] commit_id_i;
  logic               commit_kill_i;
  // Result
  logic               result_valid_o;
  logic               result_ready_i;
  logic [IdWidth-1:0] result_id_o;
  logic [4:0]         result_rd_o;
  logic [XLen-1:0]    result_data_o;
  logic               result_we_o;

  modport master (
    output issue_valid_i, accept_i, issue_id_i, rd_i, rs1_i, rs2_i, rs3_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output result_ready_i,
    input  issue_ready_o,
    input  result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o
  );

  modport slave (
    input  issue_valid_i, accept_i, issue_id_i, rd_i, rs1_i, rs2_i, rs3_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  result_ready_i,
    output issue_ready_o,
    output result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o
  );
endinterface

// File: rtl/mac4b_exec_queue.sv
// In-order execution queue: buffers issued MAC ops until commit, then computes 8-lane 4-bit MAC results.
// Latency: an entry enqueued and committed at edge t, sitting at the head, shows result_valid_o during t+2; at most one result per 3 cycles.
// Backpressure: issue_ready_o drops when the queue is full; a result is held stable until result_ready_i.
// Ports: clk_i, rst_ni (synchronous, active-low), xif (mac4b_exec_queue_if.slave: issue/commit/result).
// Option: define MAC4B_SIGNED_EN for two's-complement nibbles (default build is unsigned).
module mac4b_exec_queue #(
  parameter int Depth   = 4,
  parameter int IdWidth = 3,
  parameter int XLen    = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mac4b_exec_queue_if.slave xif
);

  localparam int IdxW = $clog2(Depth);
  localparam int PtrW = IdxW + 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, RESULT} state_e;

  // 8 lanes of nibble products summed into 11 bits, then added to the accumulator operand.
  function automatic logic [XLen-1:0] mac_f(input logic [XLen-1:0] a,
                                            input logic [XLen-1:0] b,
                                            input logic [XLen-1:0] c);
`ifdef MAC4B_SIGNED_EN
    logic signed [7:0]  p;
    logic signed [10:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) begin
      p = $signed({{4{a[4*k+3]}}, a[4*k +: 4]}) * $signed({{4{b[4*k+3]}}, b[4*k +: 4]});
      s = s + $signed({{3{p[7]}}, p});
    end
    return c + {{(XLen-11){s[10]}}, s};
`else
    logic [7:0]  p;
    logic [10:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) begin
      p = {4'b0, a[4*k +: 4]} * {4'b0, b[4*k +: 4]};
      s = s + {3'b0, p};
    end
    return c + {{(XLen-11){1'b0}}, s};
`endif
  endfunction

  // Queue state
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [Depth-1:0]   vld_q, vld_d, cmt_q, cmt_d, kill_q, kill_d;
  logic [IdWidth-1:0] id_q  [Depth];
  logic [IdWidth-1:0] id_d  [Depth];
  logic [4:0]         rd_q  [Depth];
  logic [4:0]         rd_d  [Depth];
  logic [XLen-1:0]    rs1_q [Depth];
  logic [XLen-1:0]    rs1_d [Depth];
  logic [XLen-1:0]    rs2_q [Depth];
  logic [XLen-1:0]    rs2_d [Depth];
  logic [XLen-1:0]    rs3_q [Depth];
  logic [XLen-1:0]    rs3_d [Depth];

  // FSM and result registers
  state_e             state_q, state_d;
  logic [IdWidth-1:0] res_id_q, res_id_d;
  logic [4:0]         res_rd_q, res_rd_d;
  logic [XLen-1:0]    res_data_q, res_data_d;

  logic [IdxW-1:0] wr_idx, rd_idx;
  logic            full, push, pop, new_cmt;

  assign wr_idx = wr_ptr_q[IdxW-1:0];
  assign rd_idx = rd_ptr_q[IdxW-1:0];
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full   = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                  (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign push   = xif.issue_valid_i && !full && xif.accept_i;
  // A commit arriving alongside its own issue lands on the entry being written.
  assign new_cmt = xif.commit_valid_i && (xif.commit_id_i == xif.issue_id_i);

  assign xif.issue_ready_o  = !full;
  assign xif.result_valid_o = (state_q == RESULT);
  assign xif.result_we_o    = (state_q == RESULT);
  assign xif.result_id_o    = res_id_q;
  assign xif.result_rd_o    = res_rd_q;
  assign xif.result_data_o  = res_data_q;

  // Queue next-state: commit flag updates, pop of the head, push at the tail.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    cmt_d    = cmt_q;
    kill_d   = kill_q;
    id_d     = id_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rs3_d    = rs3_q;

    for (int i = 0; i < Depth; i++) begin
      if (xif.commit_valid_i && vld_q[i] && (id_q[i] == xif.commit_id_i)) begin
        cmt_d[i]  = 1'b1;
        kill_d[i] = kill_q[i] | xif.commit_kill_i;
      end
    end

    if (pop) begin
      vld_d[rd_idx]  = 1'b0;
      cmt_d[rd_idx]  = 1'b0;
      kill_d[rd_idx] = 1'b0;
      rd_ptr_d       = rd_ptr_q + PtrW'(1);
    end

    // Push never targets the popped slot: that needs the queue full, which blocks push.
    if (push) begin
      vld_d[wr_idx]  = 1'b1;
      cmt_d[wr_idx]  = new_cmt;
      kill_d[wr_idx] = new_cmt && xif.commit_kill_i;
      id_d[wr_idx]   = xif.issue_id_i;
      rd_d[wr_idx]   = xif.rd_i;
      rs1_d[wr_idx]  = xif.rs1_i;
      rs2_d[wr_idx]  = xif.rs2_i;
      rs3_d[wr_idx]  = xif.rs3_i;
      wr_ptr_d       = wr_ptr_q + PtrW'(1);
    end
  end

  // FSM: works on the head entry only, so results leave strictly in issue order.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    res_id_d   = res_id_q;
    res_rd_d   = res_rd_q;
    res_data_d = res_data_q;
    case (state_q)
      IDLE: begin
        if (vld_q[rd_idx]) begin
          if (kill_q[rd_idx]) begin
            pop = 1'b1;
          end else if (cmt_q[rd_idx]) begin
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        res_id_d   = id_q[rd_idx];
        res_rd_d   = rd_q[rd_idx];
        res_data_d = mac_f(rs1_q[rd_idx], rs2_q[rd_idx], rs3_q[rd_idx]);
        state_d    = RESULT;
      end
      RESULT: begin
        if (xif.result_ready_i) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      vld_q      <= '0;
      cmt_q      <= '0;
      kill_q     <= '0;
      res_id_q   <= '0;
      res_rd_q   <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      vld_q      <= vld_d;
      cmt_q      <= cmt_d;
      kill_q     <= kill_d;
      res_id_q   <= res_id_d;
      res_rd_q   <= res_rd_d;
      res_data_q <= res_data_d;
    end
  end

  // Payload storage is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    id_q  <= id_d;
    rd_q  <= rd_d;
    rs1_q <= rs1_d;
    rs2_q <= rs2_d;
    rs3_q <= rs3_d;
  end

endmodule

// File: tb/tb_mac4b_exec_queue.sv
module tb_mac4b_exec_queue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac4b_exec_queue_if #(.IdWidth(3), .XLen(32)) xif ();

  mac4b_exec_queue #(.Depth(4), .IdWidth(3), .XLen(32)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .xif   (xif)
  );

  typedef struct packed {
    logic [2:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference MAC using plain integer arithmetic.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    int s = 0;
    for (int k = 0; k < 8; k++) begin
      int x = int'((a >> (4 * k)) & 32'hF);
      int y = int'((b >> (4 * k)) & 32'hF);
`ifdef MAC4B_SIGNED_EN
      if (x > 7) x = x - 16;
      if (y > 7) y = y - 16;
`endif
      s = s + x * y;
    end
    return c + 32'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] id, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input bit cmt_now,
                       input bit keep, input logic [31:0] exp_data);
    xif.issue_valid_i = 1'b1;
    xif.accept_i      = 1'b1;
    xif.issue_id_i    = id;
    xif.rd_i          = rd;
    xif.rs1_i         = a;
    xif.rs2_i         = b;
    xif.rs3_i         = c;
    if (cmt_now) begin
      xif.commit_valid_i = 1'b1;
      xif.commit_id_i    = id;
      xif.commit_kill_i  = 1'b0;
    end
    if (keep) sb.push_back('{id: id, rd: rd, data: exp_data});
    tick();
    xif.issue_valid_i  = 1'b0;
    xif.accept_i       = 1'b0;
    xif.commit_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [2:0] id, input bit kill);
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = id;
    xif.commit_kill_i  = kill;
    tick();
    xif.commit_valid_i = 1'b0;
    xif.commit_kill_i  = 1'b0;
  endtask

  // Wait (bounded) for a result, compare against the scoreboard head, hold ready low
  // for 'hold' cycles checking stability, then complete the handshake.
  task automatic expect_result(input string tag, input int hold);
    exp_t e;
    int   n = 0;
    while (!xif.result_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(xif.result_valid_o), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_hold_valid"}, 32'(xif.result_valid_o), 32'd1);
      chk({tag, "_hold_id"}, 32'(xif.result_id_o), 32'(e.id));
      chk({tag, "_hold_rd"}, 32'(xif.result_rd_o), 32'(e.rd));
      chk({tag, "_hold_data"}, xif.result_data_o, e.data);
      tick();
    end
    chk({tag, "_id"}, 32'(xif.result_id_o), 32'(e.id));
    chk({tag, "_rd"}, 32'(xif.result_rd_o), 32'(e.rd));
    chk({tag, "_data"}, xif.result_data_o, e.data);
    chk({tag, "_we"}, 32'(xif.result_we_o), 32'd1);
    xif.result_ready_i = 1'b1;
    tick();
    xif.result_ready_i = 1'b0;
    chk({tag, "_valid_after_pop"}, 32'(xif.result_valid_o), 32'd0);
  endtask

  // Over n cycles no result may appear.
  task automatic no_result(input string tag, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (xif.result_valid_o) seen = 1'b1;
      tick();
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, c;
    int          n;

    xif.issue_valid_i  = 1'b0;
    xif.accept_i       = 1'b0;
    xif.issue_id_i     = '0;
    xif.rd_i           = '0;
    xif.rs1_i          = '0;
    xif.rs2_i          = '0;
    xif.rs3_i          = '0;
    xif.commit_valid_i = 1'b0;
    xif.commit_id_i    = '0;
    xif.commit_kill_i  = 1'b0;
    xif.result_ready_i = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_valid", 32'(xif.result_valid_o), 32'd0);
    chk("rst_we", 32'(xif.result_we_o), 32'd0);
    chk("rst_id", 32'(xif.result_id_o), 32'd0);
    chk("rst_rd", 32'(xif.result_rd_o), 32'd0);
    chk("rst_data", xif.result_data_o, 32'd0);
    chk("rst_ready", 32'(xif.issue_ready_o), 32'd1);
    rst_n = 1'b1;

    // 1: commit in the same cycle as issue, result two cycles later
    issue(3'd2, 5'd5, 32'h11111111, 32'h22222222, 32'd5, 1'b1, 1'b1, 32'h00000015);
    chk("t1_lat0", 32'(xif.result_valid_o), 32'd0);
    tick();
    chk("t1_lat1", 32'(xif.result_valid_o), 32'd0);
    tick();
    chk("t1_lat2", 32'(xif.result_valid_o), 32'd1);
    expect_result("t1", 0);

    // Request without accept is ignored
    xif.issue_valid_i  = 1'b1;
    xif.accept_i       = 1'b0;
    xif.issue_id_i     = 3'd6;
    xif.commit_valid_i = 1'b1;
    xif.commit_id_i    = 3'd6;
    tick();
    xif.issue_valid_i  = 1'b0;
    xif.commit_valid_i = 1'b0;
    no_result("noaccept_ignored", 6);

    // 2: fill the queue, fifth request dropped
    for (int i = 0; i < 4; i++) begin
      chk("t2_ready_before_full", 32'(xif.issue_ready_o), 32'd1);
      a = $urandom; b = $urandom; c = $urandom;
      issue(3'(i), 5'(10 + i), a, b, c, 1'b0, 1'b1, model(a, b, c));
    end
    chk("t2_full_ready", 32'(xif.issue_ready_o), 32'd0);
    xif.issue_valid_i = 1'b1;
    xif.accept_i      = 1'b1;
    xif.issue_id_i    = 3'd4;
    xif.rd_i          = 5'd31;
    tick();
    xif.issue_valid_i = 1'b0;
    xif.accept_i      = 1'b0;
    no_result("t2_uncommitted_wait", 4);
    commit(3'd0, 1'b0);
    expect_result("t2_id0", 0);
    chk("t2_ready_after_pop", 32'(xif.issue_ready_o), 32'd1);
    commit(3'd1, 1'b0);
    commit(3'd2, 1'b0);
    commit(3'd3, 1'b0);
    expect_result("t2_id1", 0);
    expect_result("t2_id2", 0);
    expect_result("t2_id3", 0);
    commit(3'd4, 1'b0);
    no_result("t2_fifth_not_stored", 8);

    // 3: killed entry retires silently
    a = $urandom; b = $urandom; c = $urandom;
    issue(3'd1, 5'd7, a, b, c, 1'b0, 1'b0, 32'd0);
    a = $urandom; b = $urandom; c = $urandom;
    issue(3'd2, 5'd8, a, b, c, 1'b0, 1'b1, model(a, b, c));
    commit(3'd1, 1'b1);
    commit(3'd2, 1'b0);
    expect_result("t3_id2", 0);
    no_result("t3_no_killed", 6);

    // 4: result held stable under backpressure
    a = $urandom; b = $urandom; c = $urandom;
    issue(3'd3, 5'd9, a, b, c, 1'b1, 1'b1, model(a, b, c));
    expect_result("t4", 3);

    // 5: reset while a result is pending
    a = $urandom; b = $urandom; c = $urandom;
    issue(3'd5, 5'd3, a, b, c, 1'b1, 1'b0, 32'd0);
    n = 0;
    while (!xif.result_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("t5_valid_before_rst", 32'(xif.result_valid_o), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_valid_after_rst", 32'(xif.result_valid_o), 32'd0);
    chk("t5_ready_after_rst", 32'(xif.issue_ready_o), 32'd1);
    chk("t5_id_after_rst", 32'(xif.result_id_o), 32'd0);
    chk("t5_data_after_rst", xif.result_data_o, 32'd0);
    commit(3'd5, 1'b0);
    no_result("t5_stale_gone", 8);

    // 6: all-ones nibble operand
`ifdef MAC4B_SIGNED_EN
    issue(3'd6, 5'd1, 32'hFFFFFFFF, 32'h11111111, 32'd0, 1'b1, 1'b1, 32'hFFFFFFF8);
`else
    issue(3'd6, 5'd1, 32'hFFFFFFFF, 32'h11111111, 32'd0, 1'b1, 1'b1, 32'h00000078);
`endif
    expect_result("t6", 0);

    // Random operands, back-to-back committed entries
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; c = $urandom;
      issue(3'(i + 4), 5'(20 + i), a, b, c, 1'b1, 1'b1, model(a, b, c));
    end
    expect_result("b2b_0", 0);
    expect_result("b2b_1", 1);
    expect_result("b2b_2", 0);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
